// File: rtl/xnor_frame_checker.sv
// Bit-compare checker: registers XNOR of accepted (a, b) pairs and reports a
// saturating per-frame mismatch count with an all-match flag over valid/ready.
module xnor_frame_checker #(
    parameter int unsigned FRAME_LEN = 16,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             y,
    output logic             y_valid,
    output logic [CNT_W-1:0] mism_cnt,
    output logic             all_match,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic {
        StCollect,
        StHold
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             y_q, y_d;
    logic             y_valid_q, y_valid_d;
    logic [CNT_W-1:0] mism_cnt_q, mism_cnt_d;
    logic             all_match_q, all_match_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] acc_next;

    // Count including the current pair; holds at CNT_MAX instead of wrapping.
    always_comb begin
        acc_next = acc_q;
        if ((a ^ b) && (acc_q != CNT_MAX)) begin
            acc_next = acc_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        y_d         = y_q;
        y_valid_d   = 1'b0;
        mism_cnt_d  = mism_cnt_q;
        all_match_d = all_match_q;
        out_valid_d = out_valid_q;
        case (state_q)
            StCollect: begin
                if (in_valid) begin
                    y_d       = ~(a ^ b);
                    y_valid_d = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        mism_cnt_d  = acc_next;
                        all_match_d = (acc_next == '0);
                        out_valid_d = 1'b1;
                        acc_d       = '0;
                        idx_d       = '0;
                        state_d     = StHold;
                    end else begin
                        acc_d = acc_next;
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            StHold: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StCollect;
                end
            end
            default: state_d = StCollect;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StCollect;
            acc_q       <= '0;
            idx_q       <= '0;
            y_q         <= 1'b0;
            y_valid_q   <= 1'b0;
            mism_cnt_q  <= '0;
            all_match_q <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            y_q         <= y_d;
            y_valid_q   <= y_valid_d;
            mism_cnt_q  <= mism_cnt_d;
            all_match_q <= all_match_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == StCollect);
    assign y         = y_q;
    assign y_valid   = y_valid_q;
    assign mism_cnt  = mism_cnt_q;
    assign all_match = all_match_q;
    assign out_valid = out_valid_q;

endmodule
